// File: rtl/decim_ctrl.sv
// decim_ctrl: frame controller that sits in front of a decimator.
// After a start request it discards a programmable number of warm-up samples,
// then enables the decimator and counts its kept outputs until the frame
// length is reached (or forever when the length is zero).
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   start_i, abort_i   frame start request / frame termination
//   frame_len_i        decimated outputs per frame (0 = continuous)
//   warmup_i           input samples discarded after start
//   in_data_i/valid_i  upstream sample stream
//   dec_en_o           decimator enable (RUN only)
//   dec_data_o/valid_o sample stream to decimator (valid gated to RUN)
//   dec_out_valid_i    decimator kept-sample strobe
//   busy_o, done_o     status; done_o is a one-cycle frame-complete pulse
//   state_o            FSM state (IDLE=0, WARMUP=1, RUN=2, DONE=3)
//   frame_cnt_o        outputs counted in current or last frame
module decim_ctrl #(
   parameter int unsigned DATA_BW   = 8,
   parameter int unsigned FRAME_BW  = 16,
   parameter int unsigned WARMUP_BW = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [FRAME_BW-1:0]  frame_len_i,
   input  logic [WARMUP_BW-1:0] warmup_i,
   input  logic [DATA_BW-1:0]   in_data_i,
   input  logic                 in_valid_i,
   output logic                 dec_en_o,
   output logic [DATA_BW-1:0]   dec_data_o,
   output logic                 dec_valid_o,
   input  logic                 dec_out_valid_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [1:0]           state_o,
   output logic [FRAME_BW-1:0]  frame_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [FRAME_BW-1:0]  len_q;
   logic [FRAME_BW-1:0]  cnt_q;
   logic [FRAME_BW-1:0]  cnt_inc;
   logic [WARMUP_BW-1:0] warm_q;
   logic                 start_ok;

   assign cnt_inc  = cnt_q + FRAME_BW'(1);
   assign start_ok = start_i && !abort_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort always wins over a completing output
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = (warmup_i != '0) ? S_WARMUP : S_RUN;
            end
         end
         S_WARMUP: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (in_valid_i && (warm_q == WARMUP_BW'(1))) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (dec_out_valid_i && (len_q != '0) && (cnt_inc == len_q)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Frame length latch, warm-up down-counter and output counter.
   // The output counter still counts a final output that coincides with abort.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         len_q  <= '0;
         warm_q <= '0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  len_q  <= frame_len_i;
                  warm_q <= warmup_i;
                  cnt_q  <= '0;
               end
            end
            S_WARMUP: begin
               if (in_valid_i && (warm_q != '0)) begin
                  warm_q <= warm_q - WARMUP_BW'(1);
               end
            end
            S_RUN: begin
               if (dec_out_valid_i) begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs are pure decodes of the state register
   assign state_o     = 2'(state_q);
   assign busy_o      = (state_q == S_WARMUP) || (state_q == S_RUN);
   assign done_o      = (state_q == S_DONE);
   assign dec_en_o    = (state_q == S_RUN);
   assign dec_valid_o = (state_q == S_RUN) && in_valid_i;
   assign dec_data_o  = in_data_i;
   assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_decim_ctrl.sv
// Directed testbench for decim_ctrl with hand-computed expectations.
module tb_decim_ctrl;

   localparam int unsigned DATA_BW   = 8;
   localparam int unsigned FRAME_BW  = 16;
   localparam int unsigned WARMUP_BW = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic                 abort;
   logic [FRAME_BW-1:0]  frame_len;
   logic [WARMUP_BW-1:0] warmup;
   logic [DATA_BW-1:0]   in_data;
   logic                 in_valid;
   logic                 dec_en;
   logic [DATA_BW-1:0]   dec_data;
   logic                 dec_valid;
   logic                 dec_out_valid;
   logic                 busy;
   logic                 done;
   logic [1:0]           state;
   logic [FRAME_BW-1:0]  frame_cnt;

   int checks = 0;
   int errors = 0;

   decim_ctrl #(
      .DATA_BW  (DATA_BW),
      .FRAME_BW (FRAME_BW),
      .WARMUP_BW(WARMUP_BW)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .start_i        (start),
      .abort_i        (abort),
      .frame_len_i    (frame_len),
      .warmup_i       (warmup),
      .in_data_i      (in_data),
      .in_valid_i     (in_valid),
      .dec_en_o       (dec_en),
      .dec_data_o     (dec_data),
      .dec_valid_o    (dec_valid),
      .dec_out_valid_i(dec_out_valid),
      .busy_o         (busy),
      .done_o         (done),
      .state_o        (state),
      .frame_cnt_o    (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and checks happen 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; dec_out_valid = 1'b0;
   endtask

   task automatic do_start(input logic [FRAME_BW-1:0] len, input logic [WARMUP_BW-1:0] wu);
      frame_len = len; warmup = wu; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      frame_len = '0; warmup = '0; in_data = '0;
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_cnt", 32'(frame_cnt), 32'd0);
      check("reset_dec_en", 32'(dec_en), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Warm-up 3, length 2, continuous samples, decimator keeps every 4th input
      do_start(16'd2, 8'd3);
      check("w3_state_warmup", 32'(state), 32'd1);
      for (int i = 1; i <= 11; i++) begin
         in_data = 8'(i * 3);
         in_valid = 1'b1;
         dec_out_valid = (i >= 4) && (((i - 3) % 4) == 0);
         #1;
         check("w3_dec_valid", 32'(dec_valid), (i >= 4) ? 32'd1 : 32'd0);
         check("w3_dec_en", 32'(dec_en), (i >= 4) ? 32'd1 : 32'd0);
         check("w3_dec_data", 32'(dec_data), 32'(8'(i * 3)));
         check("w3_busy", 32'(busy), 32'd1);
         check("w3_state", 32'(state), (i >= 4) ? 32'd2 : 32'd1);
         tick();
      end
      idle_inputs();
      #1;
      check("w3_done_state", 32'(state), 32'd3);
      check("w3_done_pulse", 32'(done), 32'd1);
      check("w3_cnt", 32'(frame_cnt), 32'd2);
      check("w3_done_busy", 32'(busy), 32'd0);
      tick();
      check("w3_idle", 32'(state), 32'd0);
      check("w3_done_low", 32'(done), 32'd0);
      check("w3_cnt_hold", 32'(frame_cnt), 32'd2);

      // Warm-up 0, length 1
      do_start(16'd1, 8'd0);
      check("w0_run", 32'(state), 32'd2);
      check("w0_cnt_cleared", 32'(frame_cnt), 32'd0);
      dec_out_valid = 1'b1;
      tick();
      dec_out_valid = 1'b0;
      check("w0_done", 32'(state), 32'd3);
      check("w0_done_pulse", 32'(done), 32'd1);
      check("w0_cnt", 32'(frame_cnt), 32'd1);
      tick();
      check("w0_idle", 32'(state), 32'd0);

      // Abort together with the final output: no done, count reaches L
      do_start(16'd2, 8'd0);
      dec_out_valid = 1'b1;
      tick();
      check("ab_cnt1", 32'(frame_cnt), 32'd1);
      abort = 1'b1;
      tick();
      idle_inputs();
      check("ab_idle", 32'(state), 32'd0);
      check("ab_no_done", 32'(done), 32'd0);
      check("ab_cnt", 32'(frame_cnt), 32'd2);
      tick();
      check("ab_no_done_later", 32'(done), 32'd0);

      // Start pulsed during RUN is ignored
      do_start(16'd3, 8'd0);
      dec_out_valid = 1'b1;
      tick();
      dec_out_valid = 1'b0;
      frame_len = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("rs_state", 32'(state), 32'd2);
      check("rs_cnt_kept", 32'(frame_cnt), 32'd1);
      dec_out_valid = 1'b1;
      tick();
      check("rs_len_kept", 32'(state), 32'd2);
      tick();
      dec_out_valid = 1'b0;
      check("rs_done", 32'(state), 32'd3);
      check("rs_cnt", 32'(frame_cnt), 32'd3);
      tick();

      // Continuous mode, 300 outputs then abort
      do_start(16'd0, 8'd0);
      dec_out_valid = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      dec_out_valid = 1'b0;
      check("ct_state", 32'(state), 32'd2);
      check("ct_cnt", 32'(frame_cnt), 32'd300);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ct_idle", 32'(state), 32'd0);
      check("ct_cnt_hold", 32'(frame_cnt), 32'd300);

      // Abort during WARMUP, and start with simultaneous abort is rejected
      do_start(16'd4, 8'd5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("aw_idle", 32'(state), 32'd0);
      start = 1'b1; abort = 1'b1;
      tick();
      idle_inputs();
      check("sa_ignored", 32'(state), 32'd0);

      // Asynchronous reset mid-WARMUP
      do_start(16'd4, 8'd5);
      in_valid = 1'b1;
      tick();
      check("ar_warmup", 32'(state), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_state", 32'(state), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_dec_valid", 32'(dec_valid), 32'd0);
      check("ar_cnt", 32'(frame_cnt), 32'd0);
      check("ar_done", 32'(done), 32'd0);
      tick();
      idle_inputs();
      rst_n = 1'b1;
      tick();
      check("ar_post_idle", 32'(state), 32'd0);
      check("ar_post_done", 32'(done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
